// File: rtl/fetch_decode_ctl.sv
// ---------------------------------------------------------------------------
// fetch_decode_ctl
//
// Multi-cycle control unit for a small MIPS-like core. It fetches one
// instruction word at a time over a simple req/ack instruction-memory port,
// decodes it, and sequences the datapath through EXEC, MEM and WB. It also
// owns the program counter.
//
// Supported opcodes (IR[31:26]):
//   000000 R-type   100011 lw   101011 sw   001000 addi   000100 beq
//   000010 j
// Any other opcode parks the unit in TRAP. TRAP raises the sticky 'illegal'
// flag and is left only through reset.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   imem_req/addr      fetch request, address = current pc
//   imem_ack/rdata     fetch completion; rdata valid with ack
//   Zero               ALU zero flag, used by beq in EXEC
//   rs, rt, rd         register fields of the instruction register
//   SEin, FuncCode     immediate field and function code of the IR
//   Regsel             write-register select (1 = rd)
//   ALUsel             ALU B operand select (1 = sign-extended immediate)
//   MemToRegSel        writeback select (1 = memory data)
//   ALUOp              00 add, 01 sub, 10 function code
//   MemRead, MemWrite  data-memory strobes, one cycle in MEM
//   RegWrite           register-file write strobe, one cycle in WB
//   pc                 current program counter
//   illegal            sticky unsupported-opcode flag
// ---------------------------------------------------------------------------
module fetch_decode_ctl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        Zero,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] SEin,
    output logic [3:0]  FuncCode,
    output logic        Regsel,
    output logic        ALUsel,
    output logic        MemToRegSel,
    output logic [1:0]  ALUOp,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [31:0] pc,
    output logic        illegal
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE = 3'd0,
        C_LW    = 3'd1,
        C_SW    = 3'd2,
        C_ADDI  = 3'd3,
        C_BEQ   = 3'd4,
        C_J     = 3'd5,
        C_ILL   = 3'd6
    } iclass_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] ir_q,    ir_d;
    logic        illegal_q, illegal_d;
    iclass_t     iclass;

    // Map the opcode field to an instruction class.
    function automatic iclass_t classify(input logic [5:0] op);
        iclass_t c;
        case (op)
            OP_RTYPE: c = C_RTYPE;
            OP_LW:    c = C_LW;
            OP_SW:    c = C_SW;
            OP_ADDI:  c = C_ADDI;
            OP_BEQ:   c = C_BEQ;
            OP_J:     c = C_J;
            default:  c = C_ILL;
        endcase
        return c;
    endfunction

    // Branch target: pc already points past the branch, so the word offset
    // is relative to pc+4 of the branch. The sum wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] cur_pc,
                                                  input logic [15:0] imm);
        logic signed [31:0] byte_off;
        byte_off = {{14{imm[15]}}, imm, 2'b00};
        return cur_pc + byte_off;
    endfunction

    // Jump target keeps the current 256 MB region.
    function automatic logic [31:0] jump_target(input logic [31:0] cur_pc,
                                                input logic [25:0] idx);
        return {cur_pc[31:28], idx, 2'b00};
    endfunction

    assign iclass = classify(ir_q[31:26]);

    // State and architectural registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'h0000_0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;

        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                case (classify(ir_q[31:26]))
                    C_J: begin
                        pc_d    = jump_target(pc_q, ir_q[25:0]);
                        state_d = S_FETCH;
                    end
                    C_ILL: begin
                        illegal_d = 1'b1;
                        state_d   = S_TRAP;
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (iclass)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ: begin
                        if (Zero) begin
                            pc_d = branch_target(pc_q, ir_q[15:0]);
                        end
                        state_d = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end

            S_MEM: begin
                if (iclass == C_LW) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end

            S_WB: state_d = S_FETCH;

            // Terminal until reset; pc and IR stay frozen.
            S_TRAP: state_d = S_TRAP;

            default: state_d = S_FETCH;
        endcase
    end

    // Outputs. Request and strobes are also gated by rst_n so they drop the
    // moment reset asserts, independent of the flop clear-to-output delay,
    // and so the request stays low for the whole reset interval.
    always_comb begin
        imem_req    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        Regsel      = 1'b0;
        ALUsel      = 1'b0;
        MemToRegSel = 1'b0;
        ALUOp       = ALU_ADD;

        if (rst_n) begin
            imem_req = (state_q == S_FETCH);
            MemRead  = (state_q == S_MEM) && (iclass == C_LW);
            MemWrite = (state_q == S_MEM) && (iclass == C_SW);
            RegWrite = (state_q == S_WB);
        end

        // Selects follow the IR; they are meaningful from DECODE until the
        // instruction retires.
        case (iclass)
            C_RTYPE: begin
                Regsel = 1'b1;
                ALUOp  = ALU_FUNC;
            end
            C_LW: begin
                ALUsel      = 1'b1;
                MemToRegSel = 1'b1;
            end
            C_ADDI: ALUsel = 1'b1;
            C_SW:   ALUsel = 1'b1;
            C_BEQ:  ALUOp  = ALU_SUB;
            default: ;
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign illegal   = illegal_q;
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign SEin      = ir_q[15:0];
    assign FuncCode  = ir_q[3:0];

endmodule

// File: tb/tb_fetch_decode_ctl.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode_ctl
//
// Directed bench for fetch_decode_ctl. Each instruction step pushes the
// expected per-cycle strobe pattern and the expected next fetch address onto
// scoreboard queues; the queues are popped as the DUT walks through the
// instruction and when it raises the next fetch request.
// ---------------------------------------------------------------------------
module tb_fetch_decode_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        Zero;
    logic [4:0]  rs, rt, rd;
    logic [15:0] SEin;
    logic [3:0]  FuncCode;
    logic        Regsel, ALUsel, MemToRegSel;
    logic [1:0]  ALUOp;
    logic        MemRead, MemWrite, RegWrite;
    logic [31:0] pc;
    logic        illegal;

    int compared   = 0;
    int mismatched = 0;

    // {MemRead, MemWrite, RegWrite} per cycle after the ack cycle
    logic [2:0]  strobe_q[$];
    logic [31:0] addr_q[$];

    fetch_decode_ctl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .Zero       (Zero),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .SEin       (SEin),
        .FuncCode   (FuncCode),
        .Regsel     (Regsel),
        .ALUsel     (ALUsel),
        .MemToRegSel(MemToRegSel),
        .ALUOp      (ALUOp),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .pc         (pc),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected strobes for cycles 1..lat-1 after the ack; lat is the cycle
    // at which the next request must appear. A strobe cycle of 0 = never.
    task automatic push_trace(input int lat, input int mr_cyc, input int mw_cyc, input int rw_cyc);
        for (int k = 1; k < lat; k++) begin
            strobe_q.push_back({(k == mr_cyc), (k == mw_cyc), (k == rw_cyc)});
        end
    endtask

    // Wait for the request, check its address, optionally stall, then ack.
    // Returns at the negedge of the DECODE cycle.
    task automatic ack_instr(input logic [31:0] instr, input int wait_cyc,
                             input logic [31:0] next_addr);
        int n;
        logic [31:0] a;
        n = 0;
        while (imem_req !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("req_wait", {31'd0, imem_req}, 32'd1);
        a = (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
        chk("fetch_addr", imem_addr, a);
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk);
            chk("addr_stable", imem_addr, a);
            chk("req_hold", {31'd0, imem_req}, 32'd1);
        end
        addr_q.push_back(next_addr);
        imem_ack   = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Walk the remaining cycles of the instruction against the scoreboard.
    task automatic drain();
        logic [2:0] s;
        while (strobe_q.size() > 0) begin
            s = strobe_q.pop_front();
            chk("strobes", {29'd0, MemRead, MemWrite, RegWrite}, {29'd0, s});
            chk("req_low", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
        end
        chk("latency_req", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        Zero       = 1'b0;

        // Reset state
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_strobes", {29'd0, MemRead, MemWrite, RegWrite}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        addr_q.push_back(32'h0);

        // R-type add $3,$1,$2 at 0
        push_trace(4, 0, 0, 3);
        ack_instr(32'h0022_1820, 0, 32'h4);
        chk("r_rs", {27'd0, rs}, 32'd1);
        chk("r_rt", {27'd0, rt}, 32'd2);
        chk("r_rd", {27'd0, rd}, 32'd3);
        chk("r_sel", {28'd0, Regsel, ALUsel, ALUOp}, {28'd0, 4'b1010});
        chk("r_func", {28'd0, FuncCode}, 32'h0);
        chk("r_pc", pc, 32'h4);
        drain();

        // lw with two stall cycles at 4
        push_trace(5, 3, 0, 4);
        ack_instr(32'h8C43_0008, 2, 32'h8);
        chk("lw_sel", {27'd0, MemToRegSel, Regsel, ALUsel, ALUOp}, {27'd0, 5'b10100});
        chk("lw_sein", {16'd0, SEin}, 32'h8);
        drain();

        // beq taken back onto itself
        Zero = 1'b1;
        push_trace(3, 0, 0, 0);
        ack_instr(32'h1000_FFFF, 0, 32'h8);
        chk("beq_aluop", {30'd0, ALUOp}, 32'd1);
        chk("beq_sel", {29'd0, Regsel, ALUsel, MemToRegSel}, 32'd0);
        drain();

        // beq not taken
        Zero = 1'b0;
        push_trace(3, 0, 0, 0);
        ack_instr(32'h1000_FFFF, 0, 32'hC);
        drain();

        // addi at 12
        push_trace(4, 0, 0, 3);
        ack_instr(32'h2001_0005, 0, 32'h10);
        chk("addi_sel", {27'd0, MemToRegSel, Regsel, ALUsel, ALUOp}, {27'd0, 5'b00100});
        drain();

        // sw at 16
        push_trace(4, 0, 3, 0);
        ack_instr(32'hAC43_0004, 0, 32'h14);
        chk("sw_alusel", {31'd0, ALUsel}, 32'd1);
        drain();

        // j at 20 -> 0x40
        push_trace(2, 0, 0, 0);
        ack_instr(32'h0800_0010, 0, 32'h40);
        drain();

        // Illegal opcode at 0x40: next fetch only after a reset
        ack_instr(32'hFC00_0000, 0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("trap_req", {31'd0, imem_req}, 32'd0);
            chk("trap_strobes", {29'd0, MemRead, MemWrite, RegWrite}, 32'd0);
        end
        chk("trap_illegal", {31'd0, illegal}, 32'd1);
        chk("trap_pc", pc, 32'h44);
        rst_n = 1'b0;
        #1;
        chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        chk("trap_rst_pc", pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Taken beq from 0 wraps below zero, then fetch at top wraps to 0
        Zero = 1'b1;
        push_trace(3, 0, 0, 0);
        ack_instr(32'h1000_FFFE, 0, 32'hFFFF_FFFC);
        drain();
        Zero = 1'b0;
        push_trace(4, 0, 0, 3);
        ack_instr(32'h0022_1820, 0, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        drain();

        // Reset in the middle of a pending fetch, with an ack during reset
        chk("mf_addr", imem_addr, addr_q.size() > 0 ? addr_q.pop_front() : 32'hDEAD_BEEF);
        rst_n      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0800_0010;
        #1;
        chk("mf_req_drop", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("mf_pc_hold", pc, 32'h0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        addr_q.push_back(32'h0);

        // sw interrupted by reset during MEM
        ack_instr(32'hAC43_0004, 0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("sw_mem_write", {31'd0, MemWrite}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("sw_rst_write", {31'd0, MemWrite}, 32'd0);
        chk("sw_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch restarts at RESET_PC
        push_trace(4, 0, 0, 3);
        ack_instr(32'h0022_1820, 0, 32'h4);
        chk("restart_pc", pc, 32'h4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_decode_ctl.md
FETCH_DECODE_CTL -- requirements
Module: fetch_decode_ctl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: imem_req  out  1  instruction fetch request.
REQ-005 Port: imem_addr  out  32  fetch address, equal to current PC.
REQ-006 Port: imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
REQ-007 Port: imem_rdata  in  32  fetched instruction word.
REQ-008 Port: Zero  in  1  ALU zero flag from the datapath.
REQ-009 Port: rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
REQ-010 Port: SEin  out  16  IR[15:0]; FuncCode  out  4  IR[3:0].
REQ-011 Port: Regsel, ALUsel, MemToRegSel  out  1 each  write-reg (1=rd), ALU B (1=SE imm), writeback (1=memory) selects.
REQ-012 Port: ALUOp  out  2  00 add, 01 sub, 10 use FuncCode.
REQ-013 Port: MemRead, MemWrite, RegWrite  out  1 each  datapath strobes.
REQ-014 Port: pc  out  32  current PC; illegal  out  1  sticky unsupported-opcode flag.

Function
REQ-015 FSM states FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-016 FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack; on imem_ack, IR<=imem_rdata, pc<=pc+4 (mod 2^32), go DECODE.
REQ-017 imem_ack while imem_req=0 is ignored.
REQ-018 DECODE on IR[31:26]: 000000 R-type, 100011 lw, 101011 sw, 001000 addi, 000100 beq -> EXEC; 000010 j -> pc<={pc[31:28],IR[25:0],2'b00}, go FETCH; any other -> TRAP.
REQ-019 EXEC: one cycle; R-type/addi -> WB; lw/sw -> MEM; beq -> if Zero=1 pc<=pc+{sext(IR[15:0]),2'b00} (mod 2^32), then FETCH.
REQ-020 MEM: one cycle; lw asserts MemRead and goes WB; sw asserts MemWrite and goes FETCH.
REQ-021 WB: one cycle; RegWrite=1, go FETCH.
REQ-022 RegWrite, MemWrite, MemRead SHALL be 1 only in WB, MEM(sw), MEM(lw) respectively; 0 in all other states.
REQ-023 Selects and ALUOp decoded combinationally from IR, valid DECODE through instruction end: R-type Regsel=1,ALUsel=0,ALUOp=10; lw/addi Regsel=0,ALUsel=1,ALUOp=00; sw ALUsel=1,ALUOp=00; beq ALUsel=0,ALUOp=01; MemToRegSel=1 only for lw; unspecified selects 0.
REQ-024 Latency from imem_ack cycle (FETCH) to next imem_req: j 2, beq 3, R-type/addi/sw 4, lw 5 cycles.
REQ-025 TRAP: terminal; illegal=1, imem_req=0, all strobes 0, pc frozen; exit only via reset.
REQ-026 pc wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000; no fault.

Reset
REQ-027 rst_n=0 immediately (no clock) forces: state FETCH, pc=RESET_PC, IR=0, illegal=0, all strobes 0; imem_req=0 while rst_n=0.
REQ-028 Reset mid-fetch abandons the request; first cycle after rst_n rises re-requests RESET_PC; any late imem_ack during reset is discarded.
REQ-029 Reset mid-MEM/WB SHALL drop MemWrite/RegWrite asynchronously in the same cycle.

Verification
REQ-030 R-type: imem_rdata=32'h0022_1820 (add $3,$1,$2) acked at pc 0 -> DECODE rs=1,rt=2,rd=3,Regsel=1,ALUOp=10; RegWrite=1 exactly one cycle, 3 cycles after ack; next imem_addr=4.
REQ-031 lw 32'h8C43_0008 with 2-cycle ack delay -> imem_addr stable during wait; MemRead one cycle then RegWrite with MemToRegSel=1; total 5 cycles from ack.
REQ-032 beq 32'h1000_FFFF at pc 8: Zero=1 -> next imem_addr=8; Zero=0 -> next imem_addr=12.
REQ-033 j 32'h0800_0010 -> next imem_addr=32'h0000_0040, no strobe asserted.
REQ-034 Opcode 6'b111111 -> illegal=1, imem_req stays 0 for 20 cycles; rst_n pulse -> illegal=0, imem_addr=RESET_PC.
REQ-035 rst_n=0 asserted mid-cycle during sw MEM state -> MemWrite falls before next clk edge; after release fetch restarts at RESET_PC.
